// File: rtl/axi_arbiter_2x1.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : axi_arbiter_2x1
// Purpose  : Fixed-priority arbiter, IFU (m0, read) + LSU (m1, read/write)
//            onto one AXI slave port; one outstanding transaction, timeout abort.
// Revision : 1.0
// ============================================================================
module axi_arbiter_2x1 #(
  parameter int TIMEOUT = 1023,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  // m0 (IFU) read
  input  logic              m0_arvalid,
  output logic              m0_arready,
  input  logic [ADDR_W-1:0] m0_araddr,
  input  logic [3:0]        m0_arid,
  input  logic [7:0]        m0_arlen,
  input  logic [2:0]        m0_arsize,
  input  logic [1:0]        m0_arburst,
  output logic              m0_rvalid,
  input  logic              m0_rready,
  output logic [31:0]       m0_rdata,
  output logic [1:0]        m0_rresp,
  output logic              m0_rlast,
  output logic [3:0]        m0_rid,
  // m1 (LSU) read
  input  logic              m1_arvalid,
  output logic              m1_arready,
  input  logic [ADDR_W-1:0] m1_araddr,
  input  logic [3:0]        m1_arid,
  input  logic [7:0]        m1_arlen,
  input  logic [2:0]        m1_arsize,
  input  logic [1:0]        m1_arburst,
  output logic              m1_rvalid,
  input  logic              m1_rready,
  output logic [31:0]       m1_rdata,
  output logic [1:0]        m1_rresp,
  output logic              m1_rlast,
  output logic [3:0]        m1_rid,
  // m1 (LSU) write
  input  logic              m1_awvalid,
  output logic              m1_awready,
  input  logic [ADDR_W-1:0] m1_awaddr,
  input  logic [3:0]        m1_awid,
  input  logic [7:0]        m1_awlen,
  input  logic [2:0]        m1_awsize,
  input  logic [1:0]        m1_awburst,
  input  logic              m1_wvalid,
  output logic              m1_wready,
  input  logic [31:0]       m1_wdata,
  input  logic [3:0]        m1_wstrb,
  input  logic              m1_wlast,
  output logic              m1_bvalid,
  input  logic              m1_bready,
  output logic [1:0]        m1_bresp,
  output logic [3:0]        m1_bid,
  // slave port
  output logic              s_arvalid,
  input  logic              s_arready,
  output logic [ADDR_W-1:0] s_araddr,
  output logic [3:0]        s_arid,
  output logic [7:0]        s_arlen,
  output logic [2:0]        s_arsize,
  output logic [1:0]        s_arburst,
  input  logic              s_rvalid,
  output logic              s_rready,
  input  logic [31:0]       s_rdata,
  input  logic [1:0]        s_rresp,
  input  logic              s_rlast,
  input  logic [3:0]        s_rid,
  output logic              s_awvalid,
  input  logic              s_awready,
  output logic [ADDR_W-1:0] s_awaddr,
  output logic [3:0]        s_awid,
  output logic [7:0]        s_awlen,
  output logic [2:0]        s_awsize,
  output logic [1:0]        s_awburst,
  output logic              s_wvalid,
  input  logic              s_wready,
  output logic [31:0]       s_wdata,
  output logic [3:0]        s_wstrb,
  output logic              s_wlast,
  input  logic              s_bvalid,
  output logic              s_bready,
  input  logic [1:0]        s_bresp,
  input  logic [3:0]        s_bid,
  output logic              err_timeout
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_M0 = 3'd1,
    RD_M1 = 3'd2,
    WR_M1 = 3'd3,
    ABORT = 3'd4
  } state_t;

  localparam logic [15:0] c_timeout = 16'(TIMEOUT);
  localparam logic [1:0]  c_slverr  = 2'b10;

  state_t      r_state;
  state_t      w_next;
  state_t      r_owner;
  logic [15:0] r_cnt;
  logic        r_err;

  // r_owner remembers which grant an ABORT must answer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_owner <= IDLE;
      r_cnt   <= 16'd0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE) begin
        r_cnt   <= 16'd0;
        r_owner <= w_next;
      end else if (r_state != ABORT) begin
        r_cnt <= r_cnt + 16'd1;
      end
      if ((w_next == ABORT) && (r_state != ABORT))
        r_err <= 1'b1;
    end
  end

  assign err_timeout = r_err;

  always_comb begin
    w_next     = r_state;
    m0_arready = 1'b0;
    m0_rvalid  = 1'b0;
    m0_rdata   = 32'd0;
    m0_rresp   = 2'd0;
    m0_rlast   = 1'b0;
    m0_rid     = 4'd0;
    m1_arready = 1'b0;
    m1_rvalid  = 1'b0;
    m1_rdata   = 32'd0;
    m1_rresp   = 2'd0;
    m1_rlast   = 1'b0;
    m1_rid     = 4'd0;
    m1_awready = 1'b0;
    m1_wready  = 1'b0;
    m1_bvalid  = 1'b0;
    m1_bresp   = 2'd0;
    m1_bid     = 4'd0;
    s_arvalid  = 1'b0;
    s_araddr   = '0;
    s_arid     = 4'd0;
    s_arlen    = 8'd0;
    s_arsize   = 3'd0;
    s_arburst  = 2'd0;
    s_rready   = 1'b0;
    s_awvalid  = 1'b0;
    s_awaddr   = '0;
    s_awid     = 4'd0;
    s_awlen    = 8'd0;
    s_awsize   = 3'd0;
    s_awburst  = 2'd0;
    s_wvalid   = 1'b0;
    s_wdata    = 32'd0;
    s_wstrb    = 4'd0;
    s_wlast    = 1'b0;
    s_bready   = 1'b0;

    case (r_state)
      IDLE: begin
        if (m1_awvalid && m1_wvalid) w_next = WR_M1;
        else if (m1_arvalid)         w_next = RD_M1;
        else if (m0_arvalid)         w_next = RD_M0;
      end
      RD_M0: begin
        s_arvalid  = m0_arvalid;
        s_araddr   = m0_araddr;
        s_arid     = m0_arid;
        s_arlen    = m0_arlen;
        s_arsize   = m0_arsize;
        s_arburst  = m0_arburst;
        m0_arready = s_arready;
        m0_rvalid  = s_rvalid;
        m0_rdata   = s_rdata;
        m0_rresp   = s_rresp;
        m0_rlast   = s_rlast;
        m0_rid     = s_rid;
        s_rready   = m0_rready;
        if (s_rvalid && m0_rready && s_rlast) w_next = IDLE;
        else if (r_cnt == c_timeout)          w_next = ABORT;
      end
      RD_M1: begin
        s_arvalid  = m1_arvalid;
        s_araddr   = m1_araddr;
        s_arid     = m1_arid;
        s_arlen    = m1_arlen;
        s_arsize   = m1_arsize;
        s_arburst  = m1_arburst;
        m1_arready = s_arready;
        m1_rvalid  = s_rvalid;
        m1_rdata   = s_rdata;
        m1_rresp   = s_rresp;
        m1_rlast   = s_rlast;
        m1_rid     = s_rid;
        s_rready   = m1_rready;
        if (s_rvalid && m1_rready && s_rlast) w_next = IDLE;
        else if (r_cnt == c_timeout)          w_next = ABORT;
      end
      WR_M1: begin
        s_awvalid  = m1_awvalid;
        s_awaddr   = m1_awaddr;
        s_awid     = m1_awid;
        s_awlen    = m1_awlen;
        s_awsize   = m1_awsize;
        s_awburst  = m1_awburst;
        m1_awready = s_awready;
        s_wvalid   = m1_wvalid;
        s_wdata    = m1_wdata;
        s_wstrb    = m1_wstrb;
        s_wlast    = m1_wlast;
        m1_wready  = s_wready;
        m1_bvalid  = s_bvalid;
        m1_bresp   = s_bresp;
        m1_bid     = s_bid;
        s_bready   = m1_bready;
        if (s_bvalid && m1_bready)    w_next = IDLE;
        else if (r_cnt == c_timeout)  w_next = ABORT;
      end
      ABORT: begin
        // slave side stays quiet; only the stalled master gets an error reply
        case (r_owner)
          RD_M0: begin
            m0_rvalid = 1'b1;
            m0_rresp  = c_slverr;
            m0_rlast  = 1'b1;
            if (m0_rready) w_next = IDLE;
          end
          RD_M1: begin
            m1_rvalid = 1'b1;
            m1_rresp  = c_slverr;
            m1_rlast  = 1'b1;
            if (m1_rready) w_next = IDLE;
          end
          WR_M1: begin
            m1_bvalid = 1'b1;
            m1_bresp  = c_slverr;
            if (m1_bready) w_next = IDLE;
          end
          default: w_next = IDLE;
        endcase
      end
      default: w_next = IDLE;
    endcase
  end

endmodule
`default_nettype wire
